stream_harness: RTL and testbench

STREAM_HARNESS -- requirements
Module: stream_harness

---
 rtl/stream_harness.sv | 137 +++++++++++++
 tb/tb_stream_harness.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_harness.sv
// Stream test harness: feeds a FIFO from a loadable source memory and captures
// the FIFO's output into a readback memory, discarding the filter fill words.
module stream_harness #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned SKIP      = 7,
    parameter int unsigned DRAIN_CYC = 6
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   num_samples,
    output logic [DATA_W-1:0] data_put,
    output logic              req_put,
    input  logic              full,
    input  logic [DATA_W-1:0] data_get,
    input  logic              empty,
    output logic              req_get,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   cap_count
);
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam int unsigned IDLE_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [CNT_W-1:0]  CAP_MAX   = CNT_W'(DEPTH);
    localparam logic [SKIP_W-1:0] SKIP_V    = SKIP_W'(SKIP);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        nxt;
    logic [CNT_W-1:0]  feed_ptr;
    logic [CNT_W-1:0]  num_lat;
    logic [SKIP_W-1:0] out_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [DATA_W-1:0] src [DEPTH];
    logic [DATA_W-1:0] cap [DEPTH];

    logic start_ok;
    logic feed_go;
    logic xfer;
    logic run_nxt;
    logic cap_we;

    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    assign feed_go  = (state == S_FEED) && !full && (feed_ptr < num_lat);
    assign xfer     = req_get && !empty;
    assign run_nxt  = (nxt == S_FEED) || (nxt == S_DRAIN);
    // Capture pointer is the low bits of cap_count; a full capture memory drops words
    assign cap_we   = xfer && !abort && (out_cnt == SKIP_V) && (cap_count != CAP_MAX);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) nxt = (num_samples == '0) ? S_DONE : S_FEED;
                S_FEED:         if (feed_ptr == num_lat) nxt = S_DRAIN;
                S_DRAIN:        if (!xfer && (idle_cnt == IDLE_LAST)) nxt = S_DONE;
                default:        nxt = S_IDLE;
            endcase
        end
    end

    // Run control, feed side, capture bookkeeping and status outputs
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            req_put   <= 1'b0;
            req_get   <= 1'b0;
            data_put  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            cap_count <= '0;
            feed_ptr  <= '0;
            num_lat   <= '0;
            out_cnt   <= '0;
            idle_cnt  <= '0;
        end else begin
            busy    <= run_nxt;
            done    <= (nxt == S_DONE);
            req_get <= run_nxt && !empty;
            req_put <= 1'b0;
            if (abort) begin
                req_get <= 1'b0;
            end else if (start_ok) begin
                num_lat   <= num_samples;
                feed_ptr  <= '0;
                out_cnt   <= '0;
                idle_cnt  <= '0;
                cap_count <= '0;
                overflow  <= 1'b0;
            end else begin
                if (feed_go) begin
                    req_put  <= 1'b1;
                    data_put <= src[feed_ptr[ADDR_W-1:0]];
                    feed_ptr <= feed_ptr + CNT_W'(1);
                end
                if (state == S_DRAIN) begin
                    idle_cnt <= xfer ? '0 : idle_cnt + IDLE_W'(1);
                end
                if (xfer) begin
                    if (out_cnt != SKIP_V)         out_cnt   <= out_cnt + SKIP_W'(1);
                    else if (cap_count == CAP_MAX) overflow  <= 1'b1;
                    else                           cap_count <= cap_count + CNT_W'(1);
                end
            end
        end
    end

    // Memories carry no reset; loads are locked out while a run is active
    always_ff @(posedge CLK) begin
        if (ld_we && !busy) src[ld_addr] <= ld_data;
        if (cap_we)         cap[cap_count[ADDR_W-1:0]] <= data_get;
        rb_data <= cap[rb_addr];
    end
endmodule

// File: tb/tb_stream_harness.sv
// Scoreboard bench for stream_harness: put-side words are checked against a
// queue of expected data; a loopback FIFO model closes the stream.
module tb_stream_harness;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 16;
    localparam int unsigned SAW = 3;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   num_samples = '0;
    logic [DW-1:0] data_put;
    logic          req_put;
    logic          full = 1'b0;
    logic [DW-1:0] data_get;
    logic          empty;
    logic          req_get;
    logic [AW-1:0] rb_addr = '0;
    logic [DW-1:0] rb_data;
    logic          busy, done, overflow;
    logic [AW:0]   cap_count;

    logic           s_start = 1'b0;
    logic [SAW:0]   s_num = '0;
    logic [DW-1:0]  s_data_put;
    logic           s_req_put;
    logic [DW-1:0]  s_data_get;
    logic           s_empty;
    logic           s_req_get;
    logic [SAW-1:0] s_rb_addr = '0;
    logic [DW-1:0]  s_rb_data;
    logic           s_busy, s_done, s_overflow;
    logic [SAW:0]   s_cap_count;

    int checks = 0;
    int failures = 0;
    int put_cnt = 0;
    logic [DW-1:0] put_q[$];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] sq[$];
    int            f_cnt = 0;
    int            s_cnt = 0;
    logic [DW-1:0] f_head = '0;
    logic [DW-1:0] s_head = '0;
    logic          hold = 1'b0;
    logic          full_prev = 1'b0;

    assign empty      = hold || (f_cnt == 0);
    assign data_get   = f_head;
    assign s_empty    = (s_cnt == 0);
    assign s_data_get = s_head;

    stream_harness u_dut (
        .CLK(CLK), .reset(reset),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .abort(abort), .num_samples(num_samples),
        .data_put(data_put), .req_put(req_put), .full(full),
        .data_get(data_get), .empty(empty), .req_get(req_get),
        .rb_addr(rb_addr), .rb_data(rb_data),
        .busy(busy), .done(done), .overflow(overflow), .cap_count(cap_count)
    );

    stream_harness #(.ADDR_W(SAW)) u_small (
        .CLK(CLK), .reset(reset),
        .ld_we(1'b0), .ld_addr(3'd0), .ld_data(32'd0),
        .start(s_start), .abort(1'b0), .num_samples(s_num),
        .data_put(s_data_put), .req_put(s_req_put), .full(1'b0),
        .data_get(s_data_get), .empty(s_empty), .req_get(s_req_get),
        .rb_addr(s_rb_addr), .rb_data(s_rb_data),
        .busy(s_busy), .done(s_done), .overflow(s_overflow), .cap_count(s_cap_count)
    );

    always #5 CLK = ~CLK;

    // Loopback FIFO models (first-word-fall-through)
    always @(posedge CLK) begin
        if (req_get && !empty) void'(fq.pop_front());
        if (req_put) fq.push_back(data_put);
        f_cnt  <= fq.size();
        f_head <= (fq.size() != 0) ? fq[0] : '0;
        full_prev <= full;
        if (s_req_get && !s_empty) void'(sq.pop_front());
        s_cnt  <= sq.size();
        s_head <= (sq.size() != 0) ? sq[0] : '0;
    end

    // Put-side monitor: pops the scoreboard on every req_put
    always @(negedge CLK) begin
        if (full_prev) begin
            checks++;
            if (req_put !== 1'b0) begin
                failures++;
                $display("FAIL put_while_full actual=%b required=0", req_put);
            end
        end
        if (req_put) begin
            logic [DW-1:0] exp_w;
            put_cnt++;
            checks++;
            if (put_q.size() == 0) begin
                failures++;
                $display("FAIL put_extra actual=%0h required=no_put", data_put);
            end else begin
                exp_w = put_q.pop_front();
                if (data_put !== exp_w) begin
                    failures++;
                    $display("FAIL put_data actual=%0h required=%0h", data_put, exp_w);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp_v);
        end
    endtask

    task automatic rb_chk(input int addr, input int exp_v);
        rb_addr = AW'(addr);
        tick();
        chk($sformatf("cap[%0d]", addr), 64'(rb_data), 64'(exp_v));
    endtask

    task automatic do_start(input int n);
        num_samples = (AW+1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) put_q.push_back(DW'(i));
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        chk(nm, 64'(done), 64'd1);
    endtask

    task automatic wait_puts(input int target);
        int n = 0;
        while (put_cnt < target && n < 200) begin
            tick();
            n++;
        end
        chk("put_count_reached", 64'(put_cnt), 64'(target));
    endtask

    task automatic flush();
        fq.delete();
        tick();
        tick();
    endtask

    initial begin
        int base;
        int n;
        repeat (3) tick();
        chk("rst_outputs", 64'({req_put, req_get, busy, done, overflow}), 64'd0);
        chk("rst_cap_count", 64'(cap_count), 64'd0);
        chk("rst_data_put", 64'(data_put), 64'd0);
        reset = 1'b1;
        tick();

        // Load 0..19 and run a plain loopback pass
        for (int i = 0; i < 20; i++) begin
            ld_we = 1'b1; ld_addr = AW'(i); ld_data = DW'(i);
            tick();
        end
        ld_we = 1'b0;
        push_exp(20);
        do_start(20);
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_done("t1_done");
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_cap_count", 64'(cap_count), 64'd13);
        chk("t1_overflow", 64'(overflow), 64'd0);
        chk("t1_scoreboard_left", 64'(put_q.size()), 64'd0);
        rb_chk(0, 7);
        rb_chk(12, 19);

        // Backpressure: full high for 5 cycles mid-feed
        push_exp(20);
        do_start(20);
        tick();
        tick();
        full = 1'b1;
        repeat (5) tick();
        full = 1'b0;
        wait_done("t2_done");
        chk("t2_cap_count", 64'(cap_count), 64'd13);
        chk("t2_scoreboard_left", 64'(put_q.size()), 64'd0);
        rb_chk(5, 12);

        // Zero-length run from DONE
        base = put_cnt;
        do_start(0);
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_cap_count", 64'(cap_count), 64'd0);
        repeat (5) tick();
        chk("t6_no_put", 64'(put_cnt - base), 64'd0);

        // Drain timing: 5-cycle gaps keep DRAIN, a 6-cycle gap ends it
        flush();
        hold = 1'b1;
        base = put_cnt;
        push_exp(8);
        do_start(8);
        wait_puts(base + 8);
        hold = 1'b0;
        tick();
        tick();
        for (int g = 0; g < 3; g++) begin
            hold = 1'b1;
            repeat (4) tick();
            hold = 1'b0;
            tick();
            tick();
        end
        hold = 1'b1;
        chk("t3_gap5_busy", 64'({busy, done}), 64'b10);
        repeat (5) tick();
        chk("t3_idle5_busy", 64'({busy, done}), 64'b10);
        tick();
        chk("t3_idle6_done", 64'({busy, done}), 64'b01);
        hold = 1'b0;
        flush();

        // Abort with simultaneous start during FEED
        base = put_cnt;
        push_exp(2);
        do_start(20);
        tick();
        tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("t4_req_put", 64'(req_put), 64'd0);
        chk("t4_busy_done", 64'({busy, done}), 64'd0);
        repeat (4) tick();
        chk("t4_put_count", 64'(put_cnt - base), 64'd2);
        chk("t4_req_get", 64'(req_get), 64'd0);
        flush();

        // Asynchronous reset in DRAIN
        base = put_cnt;
        push_exp(12);
        do_start(12);
        wait_puts(base + 12);
        chk("t5_busy_before", 64'(busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_flags", 64'({req_put, req_get, busy, done, overflow}), 64'd0);
        chk("t5_rst_cap_count", 64'(cap_count), 64'd0);
        chk("t5_rst_data_put", 64'(data_put), 64'd0);
        tick();
        reset = 1'b1;
        repeat (8) tick();
        chk("t5_no_put_after", 64'(put_cnt - base), 64'd12);
        chk("t5_req_get_after", 64'(req_get), 64'd0);
        flush();

        // Small capture memory overflows: 20 words into 8 slots after skip
        for (int i = 0; i < 20; i++) sq.push_back(DW'(i));
        tick();
        s_num = (SAW+1)'(1);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        n = 0;
        while (!s_done && n < 400) begin
            tick();
            n++;
        end
        chk("t7_done", 64'(s_done), 64'd1);
        chk("t7_overflow", 64'(s_overflow), 64'd1);
        chk("t7_cap_count", 64'(s_cap_count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            s_rb_addr = SAW'(i);
            tick();
            chk($sformatf("t7_cap[%0d]", i), 64'(s_rb_data), 64'(i + 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
